// File: rtl/ram_5x32_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_5x32_arbiter_if
// Brief    : Requester A/B command ports plus RAM macro pins for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface ram_5x32_arbiter_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
);
  logic                     a_valid_i;
  logic                     a_ready_o;
  logic                     a_we_i;
  logic [ADDRESS_WIDTH-1:0] a_address_i;
  logic [DATA_WIDTH-1:0]    a_data_i;
  logic [DATA_WIDTH-1:0]    a_rdata_o;
  logic                     a_rvalid_o;

  logic                     b_valid_i;
  logic                     b_ready_o;
  logic                     b_we_i;
  logic [ADDRESS_WIDTH-1:0] b_address_i;
  logic [DATA_WIDTH-1:0]    b_data_i;
  logic [DATA_WIDTH-1:0]    b_rdata_o;
  logic                     b_rvalid_o;

  logic [ADDRESS_WIDTH-1:0] ram_address_o;
  logic [DATA_WIDTH-1:0]    ram_data_o;
  logic                     ram_we_o;
  logic [DATA_WIDTH-1:0]    ram_data_i;

  // Arbiter side
  modport slave (
    input  a_valid_i, a_we_i, a_address_i, a_data_i,
    output a_ready_o, a_rdata_o, a_rvalid_o,
    input  b_valid_i, b_we_i, b_address_i, b_data_i,
    output b_ready_o, b_rdata_o, b_rvalid_o,
    output ram_address_o, ram_data_o, ram_we_o,
    input  ram_data_i
  );

  // Requesters and RAM side
  modport master (
    output a_valid_i, a_we_i, a_address_i, a_data_i,
    input  a_ready_o, a_rdata_o, a_rvalid_o,
    output b_valid_i, b_we_i, b_address_i, b_data_i,
    input  b_ready_o, b_rdata_o, b_rvalid_o,
    input  ram_address_o, ram_data_o, ram_we_o,
    output ram_data_i
  );
endinterface
`default_nettype wire

// File: rtl/ram_5x32_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_5x32_arbiter
// Brief    : Two-requester arbiter/sequencer for the single-port ram_5x32.
//            Define ARB_ROUND_ROBIN_EN for round-robin ties (else A priority).
// Revision : 1.0 - initial release
// ============================================================================
module ram_5x32_arbiter #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
) (
  input  wire logic clk_i,
  input  wire logic rst_i,
  ram_5x32_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                   state;
  state_t                   state_next;

  logic                     lat_we;
  logic                     lat_port;       // 0 = A, 1 = B
  logic [ADDRESS_WIDTH-1:0] lat_address;
  logic [DATA_WIDTH-1:0]    lat_data;

  logic                     a_rvalid;
  logic                     b_rvalid;
  logic [DATA_WIDTH-1:0]    a_rdata;
  logic [DATA_WIDTH-1:0]    b_rdata;

  logic                     grant_a;
  logic                     grant_b;
  logic                     accept;
  logic                     a_ready;
  logic                     b_ready;
  logic                     ram_we;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_b;

  // Reset state "B granted last" lets A win the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_b <= 1'b1;
    end else if (accept) begin
      last_b <= grant_b;
    end
  end

  assign grant_a = bus.a_valid_i & (~bus.b_valid_i | last_b);
`else
  assign grant_a = bus.a_valid_i;
`endif

  assign grant_b = bus.b_valid_i & ~grant_a;
  assign accept  = (state == IDLE) & (grant_a | grant_b);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    a_ready    = 1'b0;
    b_ready    = 1'b0;
    ram_we     = 1'b0;
    case (state)
      IDLE: begin
        a_ready = grant_a & ~rst_i;
        b_ready = grant_b & ~rst_i;
        if (grant_a | grant_b) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        ram_we     = lat_we;
        state_next = lat_we ? IDLE : RESP;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lat_we      <= 1'b0;
      lat_port    <= 1'b0;
      lat_address <= '0;
      lat_data    <= '0;
    end else if (accept) begin
      lat_we      <= grant_b ? bus.b_we_i      : bus.a_we_i;
      lat_port    <= grant_b;
      lat_address <= grant_b ? bus.b_address_i : bus.a_address_i;
      lat_data    <= grant_b ? bus.b_data_i    : bus.a_data_i;
    end
  end

  // RAM output is valid during RESP; capture it for the owning port only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= (state == RESP) & ~lat_port;
      b_rvalid <= (state == RESP) &  lat_port;
      if ((state == RESP) && !lat_port) begin
        a_rdata <= bus.ram_data_i;
      end
      if ((state == RESP) && lat_port) begin
        b_rdata <= bus.ram_data_i;
      end
    end
  end

  assign bus.a_ready_o     = a_ready;
  assign bus.b_ready_o     = b_ready;
  assign bus.a_rvalid_o    = a_rvalid;
  assign bus.b_rvalid_o    = b_rvalid;
  assign bus.a_rdata_o     = a_rdata;
  assign bus.b_rdata_o     = b_rdata;
  assign bus.ram_we_o      = ram_we;
  assign bus.ram_address_o = lat_address;
  assign bus.ram_data_o    = lat_data;

endmodule
`default_nettype wire

// File: doc/ram_5x32_arbiter.md
# ram_5x32_arbiter

Two-port access arbiter and sequencer for the single-port `ram_5x32` macro. Two requesters (A, B) each issue read or write commands over a valid/ready handshake. The block grants one command at a time, drives the RAM's address, data and write-enable pins, and returns read data per port with a one-cycle valid pulse. It sits between the RAM macro and its two bus-side clients.

## Interface
- `ADDRESS_WIDTH`, 5, RAM address width.
- `DATA_WIDTH`, 32, RAM data width.

- `clk_i` in 1: clock; all state changes on its rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `a_valid_i` in 1: port A command valid.
- `a_ready_o` out 1: port A command accepted this cycle.
- `a_we_i` in 1: port A command type; 1 = write, 0 = read.
- `a_address_i` in ADDRESS_WIDTH: port A address.
- `a_data_i` in DATA_WIDTH: port A write data.
- `a_rdata_o` out DATA_WIDTH: port A read data.
- `a_rvalid_o` out 1: port A read-data valid pulse.
- `b_*`: same seven ports for requester B.
- `ram_address_o` out ADDRESS_WIDTH: to RAM `address_i`.
- `ram_data_o` out DATA_WIDTH: to RAM `data_i`.
- `ram_we_o` out 1: to RAM `we_i`.
- `ram_data_i` in DATA_WIDTH: from RAM `data_o`.

## Operation
- The RAM has these properties:
  - It registers read data one edge after sampling the address with `we_i`=0.
  - It writes on the edge where `we_i`=1.
  - It reads continuously whenever `we_i`=0.
- The FSM has three states: IDLE, ACCESS, RESP.
- **IDLE**
  - `ram_we_o`=0.
  - The arbiter picks a winner among valid ports. Only the winner sees `x_ready_o`=1, driven combinationally from state and valids.
  - On an edge with `valid & ready`, the block latches the winner's `we`, address and data plus a port id, then moves to ACCESS.
- **ACCESS** (one cycle)
  - `ram_address_o`/`ram_data_o` are driven from the latched values; `ram_we_o` equals the latched `we`.
  - Write: next state is IDLE. Writes are posted and produce no response.
  - Read: next state is RESP.
- **RESP** (one cycle)
  - `ram_we_o`=0 and the address is held.
  - At the closing edge, `ram_data_i` is captured into the owning port's `x_rdata_o` and that port's `x_rvalid_o` is set.
  - Next state is IDLE.
- **Read data and valid**
  - `x_rvalid_o` is high for exactly one cycle: the first IDLE cycle after RESP.
  - `x_rdata_o` holds its value until that port's next read response. The other port's rdata and rvalid are untouched.
- **Requester rules**
  - Hold `x_valid_i` and the payload stable until the accept edge.
  - Dropping valid before ready is illegal.
- **Arbitration:** see Configuration. A single valid port always wins.
- RAM contents are not affected by reset.

## Timing
- Accept edge E0 → RAM write or read sample at E1.
- Read data is captured at E2; `x_rvalid_o` is high in the cycle starting at E2.
- Read latency is 2 cycles from the accept edge.
- Throughput: one read per 3 cycles, one write per 2 cycles. The next command may be accepted in the same cycle that `x_rvalid_o` is high.
- Reset values:
  - FSM = IDLE.
  - `a_ready_o`=`b_ready_o`=0 while `rst_i`=1.
  - `a_rvalid_o`=`b_rvalid_o`=0.
  - `a_rdata_o`=`b_rdata_o`=0.
  - `ram_we_o`=0, `ram_address_o`=0, `ram_data_o`=0.
  - Round-robin pointer = "B last granted", so A wins first.
- Reset mid-operation:
  - Any state returns to IDLE immediately and `ram_we_o` drops asynchronously. A write in ACCESS is abandoned and the memory keeps its old value.
  - A pending read response is discarded with no rvalid.
- Addresses span the full range 0 to 2^ADDRESS_WIDTH−1 with no remapping. Data passes through unmodified.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - When both ports are valid in IDLE, the grant goes to the port not granted last.
  - The pointer updates only on an accept edge.
- `ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority: A always wins on a tie; B is granted only when `a_valid_i`=0.
  - No pointer register exists.

## Test plan
- **Write then read on A:** A writes 0xDEADBEEF to address 3, then A reads address 3.
  - The RAM sees `we`=1 at address 3 during the ACCESS cycle.
  - `a_rvalid_o` is high 2 cycles after the read accept edge, with `a_rdata_o`=0xDEADBEEF.
  - `b_rvalid_o` stays 0.
- **Tie, round-robin (macro defined):** both ports hold valid reads of addresses 1 (A) and 2 (B) continuously.
  - Grant order is A, B, A, B, with accepts spaced 3 cycles apart.
- **Tie, fixed priority (macro undefined):** same stimulus.
  - Only A is accepted while `a_valid_i`=1.
  - B is accepted in the first IDLE cycle after A drops valid.
- **Boundary address and cross-port isolation:**
  - A writes 0xFFFFFFFF to address 31; B writes 0x0 to address 0.
  - A read of address 31 returns 0xFFFFFFFF; B read of address 0 returns 0x0.
  - Each port's rdata holds between its own responses.
- **Reset during write:** assert `rst_i` during the ACCESS cycle of a write of 0x12345678 to address 5, where address 5 previously held 0xA5A5A5A5.
  - `ram_we_o` drops immediately; all outputs take their reset values.
  - A read of address 5 after reset returns 0xA5A5A5A5.
- **Reset during RESP of a B read:**
  - `b_rvalid_o` never pulses and `b_rdata_o`=0.
  - The first grant after reset goes to A when both ports are valid.
